// File: rtl/core_mem_stage.sv
// Memory stage: captures execute results, runs load/store accesses over req/gnt/rvalid and
// emits one registered write-back record per instruction. MEM_STALL_CNT_EN adds a stall-cycle counter.
module core_mem_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            ex_valid_i,
   input  logic [6:0]      opcode_i,
   input  logic [2:0]      funct3_i,
   input  logic [6:0]      funct7_i,
   input  logic [4:0]      rd_i,
   input  logic            reg_write_i,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic [XLEN-1:0] mul_result_i,
   input  logic [XLEN-1:0] store_data_i,
   output logic            mem_stall_o,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [3:0]      dmem_be_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   input  logic            dmem_gnt_i,
   input  logic            dmem_rvalid_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic            wb_valid_o,
   output logic            wb_reg_write_o,
   output logic [4:0]      wb_rd_o,
   output logic [XLEN-1:0] wb_data_o,
   output logic            mem_misaligned_o,
   output logic [31:0]     mem_stall_cnt_o
);

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      logic            misaligned;
   } wb_rec_t;

   state_e          state_q, state_d;
   logic            is_load, is_store, is_mem, misaligned, accept, start_access;
   logic [3:0]      be_new;
   logic [XLEN-1:0] wdata_new;

   logic [XLEN-1:0] addr_q, wdata_q;
   logic [3:0]      be_q;
   logic            we_q, rw_q;
   logic [2:0]      funct3_q;
   logic [4:0]      rd_q;

   logic [XLEN-1:0] shifted, load_data;
   wb_rec_t         new_rec, cmp_rec, wb_d, pend_d, wb_q, pend_q;

   assign is_load  = (opcode_i == OPC_LOAD);
   assign is_store = (opcode_i == OPC_STORE);
   assign is_mem   = is_load || is_store;

   assign mem_stall_o  = ((state_q == S_REQ) && !(dmem_gnt_i && we_q)) ||
                         ((state_q == S_WAIT) && !dmem_rvalid_i);
   assign accept       = ex_valid_i && !mem_stall_o;
   assign start_access = accept && is_mem && !misaligned;

   // Access size comes from funct3[1:0]; anything not byte/half is handled as a word.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      be_new     = 4'b1111;
      wdata_new  = store_data_i;
      misaligned = 1'b0;
      case (funct3_i[1:0])
         2'b00: begin
            be_new    = 4'b0001 << alu_result_i[1:0];
            wdata_new = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            be_new     = 4'b0011 << alu_result_i[1:0];
            wdata_new  = {2{store_data_i[15:0]}};
            misaligned = alu_result_i[0];
         end
         default: misaligned = |alu_result_i[1:0];
      endcase
   end

   assign shifted = dmem_rdata_i >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (funct3_q)
         3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      new_rec            = '0;
      new_rec.valid      = accept && (!is_mem || misaligned);
      new_rec.reg_write  = reg_write_i && (rd_i != 5'd0) && !is_store && !(is_mem && misaligned);
      new_rec.rd         = rd_i;
      new_rec.data       = (opcode_i == OPC_OP && funct7_i == 7'h01) ? mul_result_i : alu_result_i;
      new_rec.misaligned = is_mem && misaligned;

      cmp_rec = '0;
      if (state_q == S_REQ && dmem_gnt_i && we_q) begin
         cmp_rec.valid = 1'b1;
         cmp_rec.rd    = rd_q;
         cmp_rec.data  = addr_q;
      end else if (state_q == S_WAIT && dmem_rvalid_i) begin
         cmp_rec.valid     = 1'b1;
         cmp_rec.reg_write = rw_q;
         cmp_rec.rd        = rd_q;
         cmp_rec.data      = load_data;
      end

      // A record accepted while an access completes is parked one cycle behind it.
      wb_d   = '0;
      pend_d = '0;
      if (cmp_rec.valid) begin
         wb_d   = cmp_rec;
         pend_d = new_rec.valid ? new_rec : '0;
      end else if (pend_q.valid) begin
         wb_d   = pend_q;
         pend_d = new_rec.valid ? new_rec : '0;
      end else if (new_rec.valid) begin
         wb_d = new_rec;
      end

      state_d = state_q;
      case (state_q)
         S_REQ:   if (dmem_gnt_i) state_d = we_q ? S_IDLE : S_WAIT;
         S_WAIT:  if (dmem_rvalid_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (start_access) state_d = S_REQ;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         we_q     <= 1'b0;
         rw_q     <= 1'b0;
         funct3_q <= '0;
         rd_q     <= '0;
         wb_q     <= '0;
         pend_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q <= state_d;
         wb_q    <= wb_d;
         pend_q  <= pend_d;
         if (start_access) begin
            addr_q   <= alu_result_i;
            wdata_q  <= wdata_new;
            be_q     <= be_new;
            we_q     <= is_store;
            rw_q     <= reg_write_i && (rd_i != 5'd0);
            funct3_q <= funct3_i;
            rd_q     <= rd_i;
         end
      end
   end

   assign dmem_req_o       = (state_q == S_REQ);
   assign dmem_we_o        = we_q;
   assign dmem_be_o        = be_q;
   assign dmem_addr_o      = {addr_q[XLEN-1:2], 2'b00};
   assign dmem_wdata_o     = wdata_q;
   assign wb_valid_o       = wb_q.valid;
   assign wb_reg_write_o   = wb_q.reg_write;
   assign wb_rd_o          = wb_q.rd;
   assign wb_data_o        = wb_q.data;
   assign mem_misaligned_o = wb_q.misaligned;

`ifdef MEM_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          stall_cnt_q <= '0;
      else if (mem_stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign mem_stall_cnt_o = stall_cnt_q;
`else
   assign mem_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_core_mem_stage.sv
// Directed self-checking bench for core_mem_stage: ALU/mul write-back, stores, loads,
// misaligned accesses, reset mid-access and the optional stall counter.
module tb_core_mem_stage;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        ex_valid_i;
   logic [6:0]  opcode_i;
   logic [2:0]  funct3_i;
   logic [6:0]  funct7_i;
   logic [4:0]  rd_i;
   logic        reg_write_i;
   logic [31:0] alu_result_i, mul_result_i, store_data_i;
   logic        mem_stall_o, dmem_req_o, dmem_we_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        wb_valid_o, wb_reg_write_o, mem_misaligned_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o, mem_stall_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   // Back-to-back table: ADD, MUL (funct7 01), ADDI to x0 with funct7 01.
   logic [6:0]  b_opc [3] = '{OPC_OP, OPC_OP, OPC_IMM};
   logic [6:0]  b_f7  [3] = '{7'h00, 7'h01, 7'h01};
   logic [4:0]  b_rd  [3] = '{5'd1, 5'd2, 5'd0};
   logic [31:0] b_alu [3] = '{32'h11, 32'h99, 32'h33};
   logic [31:0] b_mul [3] = '{32'hAA, 32'h22, 32'hBB};
   logic [31:0] b_exp [3] = '{32'h11, 32'h22, 32'h33};
   logic        b_wr  [3] = '{1'b1, 1'b1, 1'b0};

   core_mem_stage #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .ex_valid_i(ex_valid_i), .opcode_i(opcode_i),
      .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
      .alu_result_i(alu_result_i), .mul_result_i(mul_result_i), .store_data_i(store_data_i),
      .mem_stall_o(mem_stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o), .wb_rd_o(wb_rd_o),
      .wb_data_o(wb_data_o), .mem_misaligned_o(mem_misaligned_o),
      .mem_stall_cnt_o(mem_stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                        input logic [31:0] mul, input logic [31:0] sd);
      ex_valid_i   = 1'b1;
      opcode_i     = opc;
      funct3_i     = f3;
      funct7_i     = f7;
      rd_i         = rd;
      reg_write_i  = rw;
      alu_result_i = alu;
      mul_result_i = mul;
      store_data_i = sd;
   endtask

   task automatic idle_ex();
      ex_valid_i = 1'b0;
   endtask

   // Load into x7: gnt_wait REQ cycles without gnt, then gnt; rv_wait WAIT cycles, then rvalid.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp,
                          input int gnt_wait, input int rv_wait);
      issue(OPC_LOAD, f3, 7'h00, 5'd7, 1'b1, addr, 32'h0, 32'h0);
      settle();
      check({tag, " accept stall"}, mem_stall_o, 1'b0);
      step();
      idle_ex();
      repeat (gnt_wait) begin
         check({tag, " req"}, dmem_req_o, 1'b1);
         step();
      end
      dmem_gnt_i = 1'b1;
      settle();
      check({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
      check({tag, " gnt stall"}, mem_stall_o, 1'b1);
      step();
      dmem_gnt_i = 1'b0;
      repeat (rv_wait) step();
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      settle();
      check({tag, " rvalid stall"}, mem_stall_o, 1'b0);
      step();
      dmem_rvalid_i = 1'b0;
      check({tag, " wb_valid"}, wb_valid_o, 1'b1);
      check({tag, " wb_data"}, wb_data_o, exp);
      check({tag, " wb_rd"}, wb_rd_o, 5'd7);
      check({tag, " wb_reg_write"}, wb_reg_write_o, 1'b1);
   endtask

   initial begin
      int stalls;
      rst_ni = 1'b0; ex_valid_i = 1'b0; opcode_i = '0; funct3_i = '0; funct7_i = '0;
      rd_i = '0; reg_write_i = 1'b0; alu_result_i = '0; mul_result_i = '0; store_data_i = '0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

      repeat (2) step();
      check("rst stall", mem_stall_o, 1'b0);
      check("rst req", dmem_req_o, 1'b0);
      check("rst we_be", {dmem_we_o, dmem_be_o}, 5'd0);
      check("rst addr", dmem_addr_o, 32'h0);
      check("rst wdata", dmem_wdata_o, 32'h0);
      check("rst wb", {wb_valid_o, wb_reg_write_o, wb_rd_o, mem_misaligned_o}, 8'd0);
      check("rst wb_data", wb_data_o, 32'h0);
      check("rst cnt", mem_stall_cnt_o, 32'h0);
      rst_ni = 1'b1;
      step();

      // Single ADD, latency 1
      issue(OPC_OP, 3'b000, 7'h00, 5'd5, 1'b1, 32'h0000_1234, 32'hDEAD_0000, 32'h0);
      settle();
      check("add stall", mem_stall_o, 1'b0);
      step();
      idle_ex();
      check("add wb_valid", wb_valid_o, 1'b1);
      check("add wb_data", wb_data_o, 32'h1234);
      check("add wb_rd", wb_rd_o, 5'd5);
      check("add wb_reg_write", wb_reg_write_o, 1'b1);
      check("add misaligned", mem_misaligned_o, 1'b0);
      step();
      check("add pulse end", wb_valid_o, 1'b0);

      // Three back-to-back ops
      for (int i = 0; i < 3; i++) begin
         issue(b_opc[i], 3'b000, b_f7[i], b_rd[i], 1'b1, b_alu[i], b_mul[i], 32'h0);
         settle();
         check("b2b stall", mem_stall_o, 1'b0);
         step();
         check("b2b wb_valid", wb_valid_o, 1'b1);
         check("b2b wb_data", wb_data_o, b_exp[i]);
         check("b2b wb_rd", wb_rd_o, b_rd[i]);
         check("b2b wb_reg_write", wb_reg_write_o, b_wr[i]);
      end
      idle_ex();
      step();
      check("b2b end", wb_valid_o, 1'b0);

      // SB 0x103, gnt after 2 REQ cycles
      issue(OPC_STORE, 3'b000, 7'h00, 5'd0, 1'b0, 32'h103, 32'h0, 32'h0000_00AB);
      settle();
      check("sb accept stall", mem_stall_o, 1'b0);
      step();
      idle_ex();
      stalls = 0;
      repeat (2) begin
         check("sb req", dmem_req_o, 1'b1);
         check("sb we", dmem_we_o, 1'b1);
         check("sb be", dmem_be_o, 4'b1000);
         check("sb wdata", dmem_wdata_o, 32'hABAB_ABAB);
         check("sb addr", dmem_addr_o, 32'h100);
         if (mem_stall_o) stalls++;
         step();
      end
      dmem_gnt_i = 1'b1;
      settle();
      check("sb gnt stall", mem_stall_o, 1'b0);
      step();
      dmem_gnt_i = 1'b0;
      check("sb stall cycles", stalls, 2);
      check("sb wb_valid", wb_valid_o, 1'b1);
      check("sb wb_reg_write", wb_reg_write_o, 1'b0);
      check("sb req drop", dmem_req_o, 1'b0);

      // SH 0x102, gnt immediate, ADD presented while the store completes
      issue(OPC_STORE, 3'b001, 7'h00, 5'd0, 1'b0, 32'h102, 32'h0, 32'h1234_BEEF);
      step();
      issue(OPC_OP, 3'b000, 7'h00, 5'd9, 1'b1, 32'h55, 32'h0, 32'h0);
      dmem_gnt_i = 1'b1;
      settle();
      check("sh be", dmem_be_o, 4'b1100);
      check("sh wdata", dmem_wdata_o, 32'hBEEF_BEEF);
      check("sh gnt stall", mem_stall_o, 1'b0);
      step();
      dmem_gnt_i = 1'b0;
      idle_ex();
      check("sh wb_valid", wb_valid_o, 1'b1);
      check("sh wb_reg_write", wb_reg_write_o, 1'b0);
      step();
      check("after sh wb_valid", wb_valid_o, 1'b1);
      check("after sh wb_data", wb_data_o, 32'h55);
      check("after sh wb_rd", wb_rd_o, 5'd9);
      step();
      check("after sh end", wb_valid_o, 1'b0);

      // Loads: gnt immediate, rvalid in the first WAIT cycle
      do_load("lb",  3'b000, 32'h102, 32'h0080_0000, 32'hFFFF_FF80, 0, 0);
      do_load("lbu", 3'b100, 32'h102, 32'h0080_0000, 32'h0000_0080, 0, 0);
      do_load("lh",  3'b001, 32'h102, 32'h8001_0000, 32'hFFFF_8001, 0, 0);
      do_load("lhu", 3'b101, 32'h102, 32'h8001_0000, 32'h0000_8001, 1, 1);
      do_load("lw",  3'b010, 32'h100, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0);
      do_load("lx",  3'b111, 32'h104, 32'h8765_4321, 32'h8765_4321, 0, 0);

      // Misaligned LW and SH: no request, flagged record
      issue(OPC_LOAD, 3'b010, 7'h00, 5'd4, 1'b1, 32'h102, 32'h0, 32'h0);
      settle();
      check("lw mis stall", mem_stall_o, 1'b0);
      step();
      idle_ex();
      check("lw mis req", dmem_req_o, 1'b0);
      check("lw mis wb_valid", wb_valid_o, 1'b1);
      check("lw mis flag", mem_misaligned_o, 1'b1);
      check("lw mis wb_reg_write", wb_reg_write_o, 1'b0);
      step();
      check("lw mis end", {wb_valid_o, mem_misaligned_o}, 2'b00);
      issue(OPC_STORE, 3'b001, 7'h00, 5'd0, 1'b0, 32'h101, 32'h0, 32'h5555);
      step();
      idle_ex();
      check("sh mis req", dmem_req_o, 1'b0);
      check("sh mis flag", {wb_valid_o, mem_misaligned_o, wb_reg_write_o}, 3'b110);
      step();

      // Reset while in WAIT, then a late rvalid
      issue(OPC_LOAD, 3'b010, 7'h00, 5'd3, 1'b1, 32'h200, 32'h0, 32'h0);
      step();
      idle_ex();
      dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i = 1'b0;
      settle();
      check("wait stall", mem_stall_o, 1'b1);
      rst_ni = 1'b0;
      settle();
      check("rst wait stall", mem_stall_o, 1'b0);
      check("rst wait addr", dmem_addr_o, 32'h0);
      step();
      rst_ni = 1'b1;
      step();
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hDEAD_BEEF;
      settle();
      check("late rvalid stall", mem_stall_o, 1'b0);
      step();
      dmem_rvalid_i = 1'b0;
      check("late rvalid wb", {wb_valid_o, wb_reg_write_o, wb_rd_o}, 7'd0);
      check("late rvalid data", wb_data_o, 32'h0);
      issue(OPC_OP, 3'b000, 7'h00, 5'd6, 1'b1, 32'h77, 32'h0, 32'h0);
      settle();
      check("post rst accept", mem_stall_o, 1'b0);
      step();
      idle_ex();
      check("post rst wb", wb_data_o, 32'h77);

      // Reset while in REQ drops the request asynchronously
      issue(OPC_STORE, 3'b010, 7'h00, 5'd0, 1'b0, 32'h300, 32'h0, 32'h1);
      step();
      idle_ex();
      check("req before rst", dmem_req_o, 1'b1);
      #2 rst_ni = 1'b0;
      settle();
      check("req async drop", dmem_req_o, 1'b0);
      check("stall async drop", mem_stall_o, 1'b0);
      step();
      rst_ni = 1'b1;
      step();

      // Stall counter: 3 REQ cycles (incl. gnt) + 2 WAIT cycles = 5
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      step();
      do_load("cnt", 3'b010, 32'h40, 32'h1, 32'h1, 2, 2);
`ifdef MEM_STALL_CNT_EN
      check("stall cnt", mem_stall_cnt_o, 32'd5);
`else
      check("stall cnt off", mem_stall_cnt_o, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
